// File: rtl/ar_rr_sel4.sv
// Round-robin select generator for a 4:1 channel mux: registered, break-before-make
// sel/enable/gnt with release, dropped-request and hold-time grant termination.
module ar_rr_sel4 #(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  // "release" is a reserved word in SystemVerilog, so the owner-done input is named rel.
  input  logic       rel,
  output logic [1:0] sel,
  output logic       enable,
  output logic [3:0] gnt,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [1:0]    pick;
  logic          pick_valid;
  logic [1:0]    idx;
  logic          hold_done;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  assign hold_done = (cnt == CW'(HOLD_MAX - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      enable  <= 1'b0;
      gnt     <= '0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sel    <= pick;
            gnt    <= 4'b0001 << pick;
            enable <= 1'b1;
            cnt    <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (rel || !req[sel] || hold_done) begin
            // Timeout only when the hold limit is the deciding end condition.
            timeout <= !rel && req[sel] && hold_done;
            enable  <= 1'b0;
            gnt     <= '0;
            ptr     <= sel + 2'd1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
